router_pkt_tx: RTL and testbench
================================

# router_pkt_tx

Packet transmitter for the 1x3 router's input port. It takes a packet command (destination address, payload length, corrupt flag) and drives the router's byte-serial input protocol: a header byte, then payload bytes, then a trailing parity byte. It stalls on the router's `busy` and computes the XOR parity on the fly. It sits between a traffic source (test harness or upstream logic) and the router's `pkt_valid`/`data_in` pins.

## Interface
- No parameters; byte width is fixed at 8 and length field at 6.
- `clock`  in  1  single clock, all state updates on rising edge
- `reset`  in  1  asynchronous, active-high reset
- `cmd_valid`  in  1  command present
- `cmd_ready`  out  1  high when a command can be accepted (IDLE only)
- `cmd_addr`  in  2  destination port, 0..2 legal
- `cmd_len`  in  6  payload byte count, 1..63 legal
- `cmd_corrupt`  in  1  when 1, the parity byte is sent inverted
- `cmd_err`  out  1  one-cycle pulse when a command is rejected
- `pl_ready`  out  1  payload byte consumed from `pl_data` at this edge
- `pl_data`  in  8  next payload byte; the source must keep it valid whenever `pl_ready` can be high
- `busy`  in  1  router busy; when 1, the current byte must be held
- `pkt_valid`  out  1  router `pkt_valid`
- `data_out`  out  8  router `data_in`
- `tx_done`  out  1  one-cycle pulse after the parity byte is transferred

## Operation
- States: IDLE, HEADER, PAYLOAD, PARITY, GAP.
- Transfer rule: the byte on `data_out` is transferred at any rising edge where state is HEADER, PAYLOAD or PARITY and `busy==0`. While `busy==1`, `data_out`, `pkt_valid`, the counter and the parity register hold.
- IDLE: `cmd_ready=1`, `pkt_valid=0`, `data_out=0`. On `cmd_valid`:
  - If `cmd_addr==3` or `cmd_len==0`: drop the command, pulse `cmd_err` next cycle, stay IDLE.
  - Otherwise: latch the fields, load `data_out={cmd_len,cmd_addr}`, set `parity` to the header value, `remaining=cmd_len`, and go to HEADER.
- HEADER/PAYLOAD: `pkt_valid=1`.
  - On a transfer with `remaining>0`: `pl_ready=1` combinationally, `data_out<=pl_data`, `parity<=parity^pl_data`, `remaining<=remaining-1`, state goes to PAYLOAD.
  - On a transfer with `remaining==0`: `data_out<=parity ^ {8{corrupt}}`, state goes to PARITY.
- PARITY: `pkt_valid=0`, `data_out`=parity byte. On transfer, go to GAP with `data_out<=0`.
- GAP: one cycle, `pkt_valid=0`, `tx_done=1`. Always returns to IDLE. `cmd_ready=0` during GAP, which guarantees at least one idle-low cycle between packets.
- `pl_ready = (state∈{HEADER,PAYLOAD}) & ~busy & (remaining!=0)`. It is never high in any other state.
- `remaining` is 6 bits. It never wraps because `cmd_len` of 0 is rejected.
- Parity is the XOR of the header and every payload byte actually transferred. Held bytes are not re-XORed.

## Timing
- Reset values: state IDLE, `pkt_valid=0`, `data_out=0x00`, `tx_done=0`, `cmd_err=0`, `pl_ready=0`, `cmd_ready=1` (combinational from IDLE), parity and counter 0.
- Reset asserted mid-packet: the packet is abandoned immediately (asynchronous) and no `tx_done` is issued. After release the block is in IDLE and the next command starts a fresh packet.
- Command accept edge to header on `data_out`: 1 cycle.
- With `busy` held low, a packet of length N occupies N+2 cycles with bytes driven (header, N payload, parity), plus 1 GAP cycle, before `cmd_ready` is high again.
- `cmd_err` goes high in the cycle after the rejecting edge, for exactly 1 cycle. `cmd_ready` stays 1 throughout.
- `busy` rising while in PARITY holds the parity byte with `pkt_valid=0` until `busy` falls.
- `busy` in IDLE and GAP is ignored.
- `cmd_valid` outside IDLE is ignored; the command is not queued.

## Test plan
- Good packet, addr 1, len 4, payload A1 B2 C3 D4, `busy=0` -> `data_out` sequence 0x11, A1, B2, C3, D4 with `pkt_valid=1`; then 0x15 with `pkt_valid=0`; `tx_done` in the next cycle; total 7 cycles from accept to `cmd_ready`.
- Same command with `cmd_corrupt=1` -> parity byte 0xEA; all other bytes identical.
- Same packet with `busy=1` for 3 cycles while B2 is on the bus -> B2 held 4 cycles, no extra `pl_ready`, parity still 0x15.
- Max packet, addr 2, len 63, `pl_data` = incrementing 0x00..0x3E -> header 0xFE, 63 payload bytes in order, parity = 0xFE XOR all payload bytes. Check the counter does not underflow.
- Illegal commands: addr 3 len 4, then addr 0 len 0 -> two `cmd_err` pulses, `pkt_valid` never rises, `pl_ready` never rises.
- Reset asserted while the third payload byte is on the bus -> `pkt_valid`/`data_out` 0 immediately, no `tx_done`. A following addr 0 len 1 payload 0x5A packet gives 0x04, 0x5A, parity 0x5E.

Source files
------------

// File: rtl/router_pkt_tx.sv
// Byte-serial packet transmitter for the router input port.
// Sends a header, then the payload, then an XOR parity byte, and stalls on busy.
//
// state   | meaning
// IDLE    | waiting for a command, cmd_ready high
// HEADER  | header byte {len,addr} on data_out
// PAYLOAD | payload byte on data_out, remaining counts bytes still to fetch
// PARITY  | parity byte on data_out, pkt_valid low
// GAP     | one-cycle gap after the packet, tx_done pulse
module router_pkt_tx (
    input  logic       clock,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_addr,
    input  logic [5:0] cmd_len,
    input  logic       cmd_corrupt,
    output logic       cmd_err,
    output logic       pl_ready,
    input  logic [7:0] pl_data,
    input  logic       busy,
    output logic       pkt_valid,
    output logic [7:0] data_out,
    output logic       tx_done
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        HEADER  = 3'd1,
        PAYLOAD = 3'd2,
        PARITY  = 3'd3,
        GAP     = 3'd4
    } state_t;

    state_t     state, state_nxt;
    logic [7:0] data_q, data_nxt;
    logic [7:0] parity_q, parity_nxt;
    logic [5:0] remaining_q, remaining_nxt;
    logic       corrupt_q, corrupt_nxt;
    logic       cmd_err_q, cmd_err_nxt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            data_q      <= 8'h00;
            parity_q    <= 8'h00;
            remaining_q <= 6'd0;
            corrupt_q   <= 1'b0;
            cmd_err_q   <= 1'b0;
        end else begin
            state       <= state_nxt;
            data_q      <= data_nxt;
            parity_q    <= parity_nxt;
            remaining_q <= remaining_nxt;
            corrupt_q   <= corrupt_nxt;
            cmd_err_q   <= cmd_err_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        data_nxt      = data_q;
        parity_nxt    = parity_q;
        remaining_nxt = remaining_q;
        corrupt_nxt   = corrupt_q;
        cmd_err_nxt   = 1'b0;
        cmd_ready     = 1'b0;
        pkt_valid     = 1'b0;
        pl_ready      = 1'b0;
        tx_done       = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    if (cmd_addr == 2'd3 || cmd_len == 6'd0) begin
                        cmd_err_nxt = 1'b1;
                    end else begin
                        data_nxt      = {cmd_len, cmd_addr};
                        parity_nxt    = {cmd_len, cmd_addr};
                        remaining_nxt = cmd_len;
                        corrupt_nxt   = cmd_corrupt;
                        state_nxt     = HEADER;
                    end
                end
            end
            HEADER, PAYLOAD: begin
                pkt_valid = 1'b1;
                if (!busy) begin
                    if (remaining_q != 6'd0) begin
                        pl_ready      = 1'b1;
                        data_nxt      = pl_data;
                        parity_nxt    = parity_q ^ pl_data;
                        remaining_nxt = remaining_q - 6'd1;
                        state_nxt     = PAYLOAD;
                    end else begin
                        data_nxt  = parity_q ^ {8{corrupt_q}};
                        state_nxt = PARITY;
                    end
                end
            end
            PARITY: begin
                if (!busy) begin
                    data_nxt  = 8'h00;
                    state_nxt = GAP;
                end
            end
            GAP: begin
                tx_done   = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                data_nxt  = 8'h00;
                state_nxt = IDLE;
            end
        endcase
    end

    assign data_out = data_q;
    assign cmd_err  = cmd_err_q;

endmodule

// File: tb/tb_router_pkt_tx.sv
// Directed bench for router_pkt_tx: byte sequences, stalls, rejects and mid-packet reset.
module tb_router_pkt_tx;

    logic       clock = 1'b0;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_addr;
    logic [5:0] cmd_len;
    logic       cmd_corrupt;
    logic       cmd_err;
    logic       pl_ready;
    logic [7:0] pl_data;
    logic       busy;
    logic       pkt_valid;
    logic [7:0] data_out;
    logic       tx_done;

    int         total = 0;
    int         bad = 0;
    int         pl_idx = 0;
    logic [7:0] pay [0:63];
    logic [7:0] par_seen;
    int         cyc_seen;

    router_pkt_tx dut (
        .clock(clock), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_corrupt(cmd_corrupt),
        .cmd_err(cmd_err), .pl_ready(pl_ready), .pl_data(pl_data),
        .busy(busy), .pkt_valid(pkt_valid), .data_out(data_out), .tx_done(tx_done)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Advances one clock; counts a payload fetch when pl_ready was high at the edge.
    task automatic step();
        logic took;
        #1;
        took = pl_ready;
        @(posedge clock);
        if (took) pl_idx++;
        #1;
        pl_data = pay[pl_idx];
    endtask

    task automatic run_pkt(input logic [1:0] a, input logic [5:0] l, input logic c,
                           input int busy_at, input int busy_n,
                           output logic [7:0] par_out, output int cyc);
        logic [7:0] exp_b [0:65];
        logic [7:0] par;
        int k;
        int held;
        par = {l, a};
        exp_b[0] = par;
        for (int i = 0; i < int'(l); i++) begin
            exp_b[i+1] = pay[i];
            par = par ^ pay[i];
        end
        exp_b[int'(l)+1] = c ? ~par : par;
        par_out = 8'hxx;
        pl_idx = 0;
        pl_data = pay[0];
        cmd_addr = a; cmd_len = l; cmd_corrupt = c; cmd_valid = 1'b1;
        chk("accept_ready", cmd_ready, 1);
        step();
        cmd_valid = 1'b0;
        k = 0; held = 0; cyc = 0;
        while (k <= int'(l) + 1 && cyc < 300) begin
            chk("byte", data_out, exp_b[k]);
            chk("pkt_valid", pkt_valid, k <= int'(l));
            chk("no_done", tx_done, 0);
            if (k == int'(l) + 1) par_out = data_out;
            if (k == busy_at && held < busy_n) begin
                busy = 1'b1;
                held++;
                #1;
                chk("stall_pl_ready", pl_ready, 0);
            end else begin
                busy = 1'b0;
            end
            step();
            if (!busy) k++;
            cyc++;
        end
        busy = 1'b0;
        chk("gap_done", tx_done, 1);
        chk("gap_pkt_valid", pkt_valid, 0);
        chk("gap_data", data_out, 0);
        chk("gap_ready", cmd_ready, 0);
        step();
        cyc++;
        chk("idle_ready", cmd_ready, 1);
        chk("idle_done", tx_done, 0);
        chk("fetched", pl_idx, int'(l));
        chk("cycles", cyc, int'(l) + 3 + busy_n);
    endtask

    initial begin
        reset = 1'b1; cmd_valid = 1'b0; cmd_addr = 2'd0; cmd_len = 6'd0;
        cmd_corrupt = 1'b0; busy = 1'b0; pl_data = 8'h00;
        for (int i = 0; i < 64; i++) pay[i] = 8'h00;
        #12;
        chk("rst_pkt_valid", pkt_valid, 0);
        chk("rst_data", data_out, 0);
        chk("rst_done", tx_done, 0);
        chk("rst_err", cmd_err, 0);
        chk("rst_pl_ready", pl_ready, 0);
        chk("rst_ready", cmd_ready, 1);
        reset = 1'b0;
        step();

        pay[0] = 8'hA1; pay[1] = 8'hB2; pay[2] = 8'hC3; pay[3] = 8'hD4;
        run_pkt(2'd1, 6'd4, 1'b0, -1, 0, par_seen, cyc_seen);
        chk("good_parity", par_seen, 8'h15);
        chk("good_cycles", cyc_seen, 7);

        run_pkt(2'd1, 6'd4, 1'b1, -1, 0, par_seen, cyc_seen);
        chk("corrupt_parity", par_seen, 8'hEA);

        run_pkt(2'd1, 6'd4, 1'b0, 2, 3, par_seen, cyc_seen);
        chk("busy_parity", par_seen, 8'h15);

        run_pkt(2'd1, 6'd4, 1'b1, 5, 2, par_seen, cyc_seen);
        chk("busy_par_parity", par_seen, 8'hEA);

        for (int i = 0; i < 64; i++) pay[i] = 8'(i);
        run_pkt(2'd2, 6'd63, 1'b0, -1, 0, par_seen, cyc_seen);
        chk("max_parity", par_seen, 8'hC1);
        chk("max_cycles", cyc_seen, 66);

        cmd_addr = 2'd3; cmd_len = 6'd4; cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        chk("err1_pulse", cmd_err, 1);
        chk("err1_ready", cmd_ready, 1);
        chk("err1_pkt_valid", pkt_valid, 0);
        chk("err1_pl_ready", pl_ready, 0);
        step();
        chk("err1_end", cmd_err, 0);
        cmd_addr = 2'd0; cmd_len = 6'd0; cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        chk("err2_pulse", cmd_err, 1);
        chk("err2_pkt_valid", pkt_valid, 0);
        step();
        chk("err2_end", cmd_err, 0);
        chk("err2_pkt_valid_after", pkt_valid, 0);
        chk("err2_pl_ready", pl_ready, 0);

        pay[0] = 8'hA1; pay[1] = 8'hB2; pay[2] = 8'hC3; pay[3] = 8'hD4;
        pl_idx = 0; pl_data = pay[0];
        cmd_addr = 2'd1; cmd_len = 6'd4; cmd_corrupt = 1'b0; cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        step(); step(); step();
        chk("pre_rst_byte", data_out, 8'hC3);
        reset = 1'b1;
        #1;
        chk("rst_mid_pkt_valid", pkt_valid, 0);
        chk("rst_mid_data", data_out, 0);
        step();
        chk("rst_mid_done", tx_done, 0);
        reset = 1'b0;
        step();
        chk("rst_mid_done2", tx_done, 0);
        chk("rst_mid_ready", cmd_ready, 1);

        pay[0] = 8'h5A;
        run_pkt(2'd0, 6'd1, 1'b0, -1, 0, par_seen, cyc_seen);
        chk("post_rst_parity", par_seen, 8'h5E);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
